// File: rtl/adder_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sub_seq
//  Purpose  : Multi-cycle WIDTH-bit add/subtract unit. Adds CHUNK bits per
//             clock, LSB chunk first, carrying between chunks in a register.
//             Valid/ready on both sides; result carries cout/ovf/zero flags.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_sub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] C_LAST_K = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // already inverted for subtraction
    logic             r_carry;  // already inverted borrow for subtraction
    logic [KW-1:0]    r_k;

    int               w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_s_next;

    // Handshake flags come straight from the state register.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    // One chunk of the ripple adder plus the result as it will look after this edge.
    always_comb begin
        w_base    = int'(r_k) * CHUNK;
        w_a_chunk = r_a[w_base +: CHUNK];
        w_b_chunk = r_b[w_base +: CHUNK];
        w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out by XOR.
        w_msb_cin = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
        w_s_next  = s;
        w_s_next[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    end

    // Control FSM and datapath registers; flags are latched on the final chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // a - b - cin is computed as a + ~b + ~cin.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_k     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s       <= w_s_next;
                    r_carry <= w_sum[CHUNK];
                    if (r_k == C_LAST_K) begin
                        r_k     <= '0;
                        cout    <= w_sum[CHUNK];
                        ovf     <= w_msb_cin ^ w_sum[CHUNK];
                        zero    <= (w_s_next == '0);
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_sub_seq
//  Purpose  : Self-checking bench for adder_sub_seq at 16/4, 4/4 and 32/8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_sub_seq;

    logic clk;
    logic rst_n;

    // Per-instance stimulus/response, index 0 = 16/4, 1 = 4/4, 2 = 32/8.
    logic        in_valid_v  [3];
    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic        out_ready_v [3];
    logic [31:0] a_v         [3];
    logic [31:0] b_v         [3];
    logic        cin_v       [3];
    logic        sub_v       [3];
    logic [31:0] s_v         [3];
    logic        cout_v      [3];
    logic        ovf_v       [3];
    logic        zero_v      [3];

    logic [15:0] s0;
    logic [3:0]  s1;
    logic [31:0] s2;

    int c_W  [3] = '{16, 4, 32};
    int c_NC [3] = '{4, 1, 4};

    int checks = 0;
    int errors = 0;

    adder_sub_seq #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .s(s0), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
    );

    adder_sub_seq #(.WIDTH(4), .CHUNK(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .s(s1), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
    );

    adder_sub_seq #(.WIDTH(32), .CHUNK(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .s(s2), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
    );

    assign s_v[0] = {16'd0, s0};
    assign s_v[1] = {28'd0, s1};
    assign s_v[2] = s2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical operands.
    task automatic ref_model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                             input logic tcin, input logic tsub,
                             output logic [31:0] rs, output logic rc,
                             output logic ro, output logic rz);
        longint m, ua, ub, ci, sa, sb, r, full;
        m  = (longint'(1) << w) - 1;
        ua = longint'({32'd0, ta}) & m;
        ub = longint'({32'd0, tb}) & m;
        ci = tcin ? 1 : 0;
        if (!tsub) begin
            full = ua + ub + ci;
            rc   = ((full >> w) & 1) != 0;
        end else begin
            full = ua - ub - ci;
            rc   = (ua >= ub + ci);  // no borrow
        end
        rs = 32'(full & m);
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        r  = tsub ? (sa - sb - ci) : (sa + sb + ci);
        ro = (r > ((longint'(1) << (w - 1)) - 1)) || (r < -(longint'(1) << (w - 1)));
        rz = ((full & m) == 0);
    endtask

    // Launch one operation and wait for out_valid; leaves the result un-acknowledged.
    task automatic start_and_wait(input int inst, input logic [31:0] ta, input logic [31:0] tb,
                                  input logic tcin, input logic tsub, output int lat);
        int budget;
        budget = 0;
        while (!in_ready_v[inst] && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        a_v[inst] = ta; b_v[inst] = tb; cin_v[inst] = tcin; sub_v[inst] = tsub;
        in_valid_v[inst] = 1'b1;
        @(posedge clk); #1;
        // Operands may change freely once accepted.
        in_valid_v[inst] = 1'b0;
        a_v[inst] = $urandom; b_v[inst] = $urandom;
        cin_v[inst] = 1'($urandom); sub_v[inst] = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid_v[inst] && lat < 100);
    endtask

    task automatic handshake(input int inst, input string tag);
        out_ready_v[inst] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[inst] = 1'b0;
        check({tag, " out_valid_after_hs"}, 64'(out_valid_v[inst]), 64'd0);
        check({tag, " in_ready_after_hs"},  64'(in_ready_v[inst]),  64'd1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          lat;
        logic [31:0] es;
        logic        ec, eo, ez;
        logic [31:0] opa, opb;
        logic        ocin, osub;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0; sub_v[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset state of every instance.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d in_ready", i),  64'(in_ready_v[i]),  64'd1);
            check($sformatf("reset%0d out_valid", i), 64'(out_valid_v[i]), 64'd0);
            check($sformatf("reset%0d s", i),         64'(s_v[i]),         64'd0);
            check($sformatf("reset%0d cout", i),      64'(cout_v[i]),      64'd0);
            check($sformatf("reset%0d ovf", i),       64'(ovf_v[i]),       64'd0);
            check($sformatf("reset%0d zero", i),      64'(zero_v[i]),      64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on the default configuration.
        for (int i = 0; i < 6; i++) begin
            start_and_wait(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d latency", i), 64'(lat),          64'd4);
            check($sformatf("vec%0d s", i),       64'(s_v[0]),       64'(vecs[i].s));
            check($sformatf("vec%0d cout", i),    64'(cout_v[0]),    64'(vecs[i].cout));
            check($sformatf("vec%0d ovf", i),     64'(ovf_v[0]),     64'(vecs[i].ovf));
            check($sformatf("vec%0d zero", i),    64'(zero_v[0]),    64'(vecs[i].zero));
            handshake(0, $sformatf("vec%0d", i));
        end

        // Backpressure: result frozen, new requests ignored.
        start_and_wait(0, 32'h1234, 32'h1111, 1'b0, 1'b0, lat);
        check("bp latency", 64'(lat), 64'd4);
        for (int c = 0; c < 10; c++) begin
            in_valid_v[0] = c[0];
            a_v[0] = $urandom; b_v[0] = $urandom;
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", c), 64'(out_valid_v[0]), 64'd1);
            check($sformatf("bp%0d in_ready", c),  64'(in_ready_v[0]),  64'd0);
            check($sformatf("bp%0d s", c),         64'(s_v[0]),         64'h2345);
            check($sformatf("bp%0d flags", c),
                  64'({cout_v[0], ovf_v[0], zero_v[0]}), 64'd0);
        end
        in_valid_v[0] = 1'b0;
        handshake(0, "bp");
        @(posedge clk); #1;
        check("bp no_spurious_op", 64'(in_ready_v[0]), 64'd1);

        // Reset in the middle of RUN discards the operation.
        a_v[0] = 32'hFFFF; b_v[0] = 32'h0001; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstrun in_ready",  64'(in_ready_v[0]),  64'd1);
        check("rstrun out_valid", 64'(out_valid_v[0]), 64'd0);
        check("rstrun s",         64'(s_v[0]),         64'd0);
        check("rstrun flags",     64'({cout_v[0], ovf_v[0], zero_v[0]}), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("rstrun hold%0d out_valid", c), 64'(out_valid_v[0]), 64'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("rstrun after%0d out_valid", c), 64'(out_valid_v[0]), 64'd0);
        end
        start_and_wait(0, 32'h00FF, 32'h0001, 1'b0, 1'b0, lat);
        check("post_rst latency", 64'(lat),    64'd4);
        check("post_rst s",       64'(s_v[0]), 64'h0100);
        check("post_rst flags",   64'({cout_v[0], ovf_v[0], zero_v[0]}), 64'd0);
        handshake(0, "post_rst");

        // Randomised sweep over all three configurations against the model.
        for (int inst = 0; inst < 3; inst++) begin
            for (int j = 0; j < 30; j++) begin
                opa  = $urandom;
                opb  = $urandom;
                ocin = 1'($urandom);
                osub = 1'($urandom);
                if (j % 6 == 0) begin
                    // Force a zero result.
                    ocin = 1'b0;
                    opb  = osub ? opa : (32'd0 - opa);
                end
                ref_model(c_W[inst], opa, opb, ocin, osub, es, ec, eo, ez);
                start_and_wait(inst, opa, opb, ocin, osub, lat);
                check($sformatf("rnd%0d_%0d latency", inst, j), 64'(lat),          64'(c_NC[inst]));
                check($sformatf("rnd%0d_%0d s", inst, j),       64'(s_v[inst]),    64'(es));
                check($sformatf("rnd%0d_%0d cout", inst, j),    64'(cout_v[inst]), 64'(ec));
                check($sformatf("rnd%0d_%0d ovf", inst, j),     64'(ovf_v[inst]),  64'(eo));
                check($sformatf("rnd%0d_%0d zero", inst, j),    64'(zero_v[inst]), 64'(ez));
                handshake(inst, $sformatf("rnd%0d_%0d", inst, j));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
